io_mac_poller: RTL
==================

# io_mac_poller

Parametrised successor to the team's single-channel I/O multiply poller. Every PERIOD clocks it reads NCH operands B[k] from consecutive input ports. For each operand it writes the 2W-bit product A*B[k] to two output ports, high word first. It then polls a status port and, if bit0 is set, reloads coefficient A from a coefficient port. It masters the shared 8/16-bit-style I/O bus (addr, data, ior_, iow_), adds a ready-driven wait-state handshake, and flags period overruns.

## Interface
- W, 8: data bus width; product is 2W bits.
- AW, 16: address width.
- NCH, 1: number of operand channels (1..16).
- PERIOD, 16: launch period in clocks (≥2).
- IN_BASE, 'h0120: B[k] read at IN_BASE+k.
- OUT_BASE, 'h0140: product high word at OUT_BASE+2k, low word at OUT_BASE+2k+1.
- STATUS_ADDR, 'h0100: status port; bit0 = new coefficient available.
- COEF_ADDR, 'h0101: coefficient port.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  out  AW  bus address, registered.
- data  inout  W  bus data; driven only in write states, else high-Z.
- ior_  out  1  read strobe, active low, registered.
- iow_  out  1  write strobe, active low, registered.
- ready  in  1  peripheral ready; sampled only while a strobe is low.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: a launch point fell inside a running sequence.

## Operation
- Reset (edge with reset=1): state=IDLE, addr=0, ior_=1, iow_=1, data high-Z, A=0, all B[k]=0, cnt=0, pending=0, busy=0, overrun=0. Reset mid-transaction aborts it on that edge with the same values. No partial write is completed.
- cnt: free-running 0..PERIOD-1, increments every non-reset edge, wraps to 0.
- Launch: in IDLE, the edge where cnt==0 enters R_ADDR for channel 0. The first launch is therefore the first edge after reset deasserts.
- Sequence per channel k=0..NCH-1: read IN_BASE+k into B[k], write P[2W-1:W] to OUT_BASE+2k, write P[W-1:0] to OUT_BASE+2k+1. P = A*B[k], unsigned, full 2W bits.
- After the last channel, read STATUS_ADDR. If captured bit0==1, read COEF_ADDR into A; otherwise skip the coefficient read.
- A changes only at the end of a sequence, so all products in one sequence use the same A. The new A applies from the next sequence.
- Read op states:
  - R_ADDR: entry sets addr.
  - R_STB: entry sets ior_=0. Held while ready=0. On an edge with ready=1, capture data and set ior_=1.
  - R_REC: one clock, then next op.
- Write op states:
  - W_ADDR: entry sets addr and the data value, and enables the driver.
  - W_STB: entry sets iow_=0. Held while ready=0. On an edge with ready=1, set iow_=1.
  - W_HOLD: one clock with data still driven.
  - The driver is released on exit unless the next state is W_ADDR.
- Sequence end: if pending==0, go to IDLE. If pending==1, enter R_ADDR (channel 0) directly on the same edge, set overrun=1, and clear pending.
- pending is set by any cnt==0 edge while state≠IDLE. Multiple missed launches collapse into one.
- ior_ and iow_ are never low together. addr is stable for the whole strobe.

## Timing
- Every op is 3 clocks with ready=1. Each extra clock of ready=0 in a strobe state adds one clock.
- Sequence length with zero wait states: 9*NCH+3 clocks, plus 3 if a coefficient is read.
- Defaults (NCH=1), launch edge L:
  - addr=0x0120 @L; ior_ 0 @L+1; B captured and ior_ 1 @L+2.
  - addr=0x0140, hi driven @L+3; iow_ 0 @L+4; iow_ 1 @L+5.
  - addr=0x0141, lo driven @L+6; iow_ 0 @L+7; iow_ 1 @L+8; data released @L+9.
  - Status read @L+9..L+11; coefficient read @L+12..L+14; IDLE @L+15; next launch @L+16.
- Product is combinational from registered A and B. It is stable before W_ADDR.

## Test plan
- Reset then defaults, ready=1, B port=0x34, status=0: writes 0x00 to 0x0140 and 0x00 to 0x0141 (A=0). No COEF read. Relaunch exactly 16 clocks later.
- Status=0x01, coef=0x12, B=0x34: next period writes 0x03 to 0x0140 and 0xA8 to 0x0141. A=0xFF with B=0xFF gives 0xFE and 0x01.
- ready held low 3 clocks in each strobe: each strobe is 3 clocks longer. Data is captured only on the ready=1 edge. addr and data are stable throughout.
- NCH=2, PERIOD=32, B0=2, B1=3, A=5: writes 0x00/0x0A to 0x0140/0x0141 and 0x00/0x0F to 0x0142/0x0143, in that order.
- PERIOD=8, defaults otherwise: overrun rises at the first sequence end. Next sequence launches on that edge. busy never drops.
- reset asserted while iow_=0: next edge iow_=1, data high-Z, overrun=0. First edge after release: addr=0x0120.

Source files
------------

// File: rtl/io_mac_poller_if.sv
// Shared I/O bus between the poller (master) and the peripherals (slave).
// The data lines are not carried here; they are a separate inout port on the poller.
interface io_mac_poller_if #(
    parameter int AW = 16
) ();
    logic [AW-1:0] addr;
    logic          ior_;
    logic          iow_;
    logic          ready;

    modport master (output addr, output ior_, output iow_, input ready);
    modport slave  (input addr, input ior_, input iow_, output ready);
endinterface

// File: rtl/io_mac_poller.sv
// Periodic I/O multiply poller: reads NCH operands, writes A*B[k] high/low, polls status and
// optionally reloads A. Strobe handshake: a strobe low is a request, ready is sampled only while
// the strobe is low, and the transfer completes on the edge where ready=1 (strobe returns high).
module io_mac_poller #(
    parameter int            W           = 8,
    parameter int            AW          = 16,
    parameter int            NCH         = 1,
    parameter int            PERIOD      = 16,
    parameter logic [AW-1:0] IN_BASE     = 16'h0120,
    parameter logic [AW-1:0] OUT_BASE    = 16'h0140,
    parameter logic [AW-1:0] STATUS_ADDR = 16'h0100,
    parameter logic [AW-1:0] COEF_ADDR   = 16'h0101
) (
    input  logic            clock,
    input  logic            reset,
    io_mac_poller_if.master bus,
    inout  wire  [W-1:0]    data,
    output logic            busy,
    output logic            overrun,
    output logic [2:0]      dbg_state,
    output logic            dbg_drive
);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = $clog2(PERIOD);

    typedef enum logic [2:0] {
        S_IDLE, S_R_ADDR, S_R_STB, S_R_REC, S_W_ADDR, S_W_STB, S_W_HOLD
    } state_t;

    typedef enum logic [2:0] {
        OP_IN, OP_HI, OP_LO, OP_STAT, OP_COEF
    } op_t;

    state_t          state, state_d;
    op_t             op, op_d;
    logic [CW-1:0]   chan, chan_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            ior_q, ior_d;
    logic            iow_q, iow_d;
    logic [W-1:0]    dout, dout_d;
    logic            oe, oe_d;
    logic            pending, pending_d;
    logic            overrun_d;
    logic            cap;
    logic            seq_end;
    logic            launch_now;
    logic [CNTW-1:0] cnt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg [NCH];
    logic [W-1:0]    b_sel;
    logic            stat_bit;
    logic [2*W-1:0]  prod;

    function automatic logic [AW-1:0] op_addr(input op_t o, input logic [CW-1:0] c);
        logic [AW-1:0] a;
        case (o)
            OP_IN:   a = IN_BASE + AW'(c);
            OP_HI:   a = OUT_BASE + (AW'(c) << 1);
            OP_LO:   a = OUT_BASE + (AW'(c) << 1) + AW'(1);
            OP_STAT: a = STATUS_ADDR;
            default: a = COEF_ADDR;
        endcase
        return a;
    endfunction

    always_comb begin
        b_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chan == CW'(i)) b_sel = b_reg[i];
        end
    end

    assign prod       = {{W{1'b0}}, a_reg} * {{W{1'b0}}, b_sel};
    assign launch_now = (cnt == '0);

    always_comb begin
        state_d   = state;
        op_d      = op;
        chan_d    = chan;
        addr_d    = addr_q;
        ior_d     = ior_q;
        iow_d     = iow_q;
        dout_d    = dout;
        oe_d      = oe;
        overrun_d = overrun;
        pending_d = pending | (launch_now && (state != S_IDLE));
        cap       = 1'b0;
        seq_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch_now) begin
                    state_d = S_R_ADDR;
                    op_d    = OP_IN;
                    chan_d  = '0;
                    addr_d  = op_addr(OP_IN, '0);
                end
            end
            S_R_ADDR: begin
                state_d = S_R_STB;
                ior_d   = 1'b0;
            end
            S_R_STB: begin
                if (bus.ready) begin
                    cap     = 1'b1;
                    ior_d   = 1'b1;
                    state_d = S_R_REC;
                end
            end
            S_R_REC: begin
                case (op)
                    OP_IN: begin
                        state_d = S_W_ADDR;
                        op_d    = OP_HI;
                        addr_d  = op_addr(OP_HI, chan);
                        dout_d  = prod[2*W-1:W];
                        oe_d    = 1'b1;
                    end
                    OP_STAT: begin
                        if (stat_bit) begin
                            state_d = S_R_ADDR;
                            op_d    = OP_COEF;
                            addr_d  = op_addr(OP_COEF, chan);
                        end else begin
                            seq_end = 1'b1;
                        end
                    end
                    default: seq_end = 1'b1;
                endcase
            end
            S_W_ADDR: begin
                state_d = S_W_STB;
                iow_d   = 1'b0;
            end
            S_W_STB: begin
                if (bus.ready) begin
                    iow_d   = 1'b1;
                    state_d = S_W_HOLD;
                end
            end
            S_W_HOLD: begin
                if (op == OP_HI) begin
                    state_d = S_W_ADDR;
                    op_d    = OP_LO;
                    addr_d  = op_addr(OP_LO, chan);
                    dout_d  = prod[W-1:0];
                end else begin
                    oe_d    = 1'b0;
                    state_d = S_R_ADDR;
                    if (chan == CW'(NCH - 1)) begin
                        op_d   = OP_STAT;
                        addr_d = op_addr(OP_STAT, chan);
                    end else begin
                        op_d   = OP_IN;
                        chan_d = chan + CW'(1);
                        addr_d = op_addr(OP_IN, chan + CW'(1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A launch point on the final edge itself also counts as missed.
        if (seq_end) begin
            pending_d = 1'b0;
            if (pending || launch_now) begin
                state_d   = S_R_ADDR;
                op_d      = OP_IN;
                chan_d    = '0;
                addr_d    = op_addr(OP_IN, '0);
                overrun_d = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            op       <= OP_IN;
            chan     <= '0;
            addr_q   <= '0;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            dout     <= '0;
            oe       <= 1'b0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            cnt      <= '0;
            a_reg    <= '0;
            stat_bit <= 1'b0;
            for (int i = 0; i < NCH; i++) b_reg[i] <= '0;
        end else begin
            state   <= state_d;
            op      <= op_d;
            chan    <= chan_d;
            addr_q  <= addr_d;
            ior_q   <= ior_d;
            iow_q   <= iow_d;
            dout    <= dout_d;
            oe      <= oe_d;
            pending <= pending_d;
            overrun <= overrun_d;
            cnt     <= (cnt == CNTW'(PERIOD - 1)) ? '0 : cnt + CNTW'(1);
            if (cap) begin
                case (op)
                    OP_IN: begin
                        for (int i = 0; i < NCH; i++) begin
                            if (chan == CW'(i)) b_reg[i] <= data;
                        end
                    end
                    OP_STAT: stat_bit <= data[0];
                    OP_COEF: a_reg    <= data;
                    default: ;
                endcase
            end
        end
    end

    assign data      = oe ? dout : {W{1'bz}};
    assign bus.addr  = addr_q;
    assign bus.ior_  = ior_q;
    assign bus.iow_  = iow_q;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
    assign dbg_drive = oe;
endmodule
